shift_unit: RTL

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// Iterative barrel-free shifter: one bit position per cycle under a 3-state FSM.
module shift_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  shift_op,
   input  logic [4:0]  shift_amt,
   input  logic [31:0] data_in,
   output logic [31:0] result,
   output logic        busy,
   output logic        done
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned AMT_W  = 5;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] OP_SLL = 3'b000;
   localparam logic [OP_W-1:0] OP_SRL = 3'b001;
   localparam logic [OP_W-1:0] OP_SRA = 3'b010;
   localparam logic [OP_W-1:0] OP_ROL = 3'b011;
   localparam logic [OP_W-1:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q,  data_d;
   logic [OP_W-1:0]     op_q,    op_d;
   logic [AMT_W-1:0]    cnt_q,   cnt_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;

   // Single-bit step for the latched op; reserved codes leave the word alone.
   function automatic logic [DATA_W-1:0] step_f(input logic [OP_W-1:0]   op,
                                                input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = d;
      case (op)
         OP_SLL:  r = {d[DATA_W-2:0], 1'b0};
         OP_SRL:  r = {1'b0, d[DATA_W-1:1]};
         OP_SRA:  r = {d[DATA_W-1], d[DATA_W-1:1]};
         OP_ROL:  r = {d[DATA_W-2:0], d[DATA_W-1]};
         OP_ROR:  r = {d[0], d[DATA_W-1:1]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               data_d = data_in;
               op_d   = shift_op;
               cnt_d  = shift_amt;
               // Zero distance or reserved op completes without shifting.
               if ((shift_amt != AMT_W'(0)) && (shift_op <= OP_ROR)) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            data_d = step_f(op_q, data_q);
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q <= AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign result = data_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
